spare_logic_monitor: RTL and testbench

- Periodic integrity checker for the chip's spare logic blocks, which are used for metal-mask ECOs.
- Samples the tie-off, inverter, NAND, NOR, mux and flop outputs of N_BLOCKS spare blocks through synchronisers.
- Scans the blocks one per cycle, compares each against its fixed expected pattern, and reports per-block fail flags, an error count and the first failing location.
- Sits in the housekeeping domain; results are read as status by the management core.

---
 rtl/spare_logic_monitor_if.sv | 39 +++
 rtl/spare_logic_monitor.sv | 168 ++++++++++++++++
 tb/tb_spare_logic_monitor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/spare_logic_monitor_if.sv
// Status/handshake bundle between the management side and the spare logic monitor.
// Carries the trigger inputs, the raw spare-block taps and the scan results.
interface spare_logic_monitor_if #(
    parameter int N_BLOCKS = 4,
    parameter int CNT_W    = 8
);
    logic                    start;
    logic                    auto_en;
    logic [27*N_BLOCKS-1:0]  spare_xz;
    logic [4*N_BLOCKS-1:0]   spare_xi;
    logic [N_BLOCKS-1:0]     spare_xib;
    logic [2*N_BLOCKS-1:0]   spare_xna;
    logic [2*N_BLOCKS-1:0]   spare_xno;
    logic [2*N_BLOCKS-1:0]   spare_xmx;
    logic [2*N_BLOCKS-1:0]   spare_xfq;
    logic [2*N_BLOCKS-1:0]   spare_xfqn;
    logic                    busy;
    logic                    done;
    logic                    result_valid;
    logic                    pass;
    logic [N_BLOCKS-1:0]     fail_map;
    logic [CNT_W-1:0]        err_count;
    logic [3:0]              first_blk;
    logic [5:0]              first_bit;

    modport master (
        output start, auto_en, spare_xz, spare_xi, spare_xib, spare_xna,
               spare_xno, spare_xmx, spare_xfq, spare_xfqn,
        input  busy, done, result_valid, pass, fail_map, err_count,
               first_blk, first_bit
    );

    modport slave (
        input  start, auto_en, spare_xz, spare_xi, spare_xib, spare_xna,
               spare_xno, spare_xmx, spare_xfq, spare_xfqn,
        output busy, done, result_valid, pass, fail_map, err_count,
               first_blk, first_bit
    );
endinterface

// File: rtl/spare_logic_monitor.sv
// Periodic integrity checker for ECO spare logic: synchronises every spare tap,
// scans one block per cycle against its fixed pattern and latches the results.
module spare_block_check (
    input  logic [26:0] xz,
    input  logic [3:0]  xi,
    input  logic        xib,
    input  logic [1:0]  xna,
    input  logic [1:0]  xno,
    input  logic [1:0]  xmx,
    input  logic [1:0]  xfq,
    input  logic [1:0]  xfqn,
    output logic [39:0] mask
);
    // Flop state itself is free; only Q/Q_N complementarity is checked.
    assign mask = {~(xfq ^ xfqn), xmx, ~xno, ~xna, ~xib, ~xi, xz};
endmodule

module spare_logic_monitor #(
    parameter int N_BLOCKS      = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int PERIOD        = 1024,
    parameter int CNT_W         = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    spare_logic_monitor_if.slave   bus
);
    localparam int RW     = 42*N_BLOCKS;
    localparam int O_XI   = 27*N_BLOCKS;
    localparam int O_XIB  = 31*N_BLOCKS;
    localparam int O_XNA  = 32*N_BLOCKS;
    localparam int O_XNO  = 34*N_BLOCKS;
    localparam int O_XMX  = 36*N_BLOCKS;
    localparam int O_XFQ  = 38*N_BLOCKS;
    localparam int O_XFQN = 40*N_BLOCKS;
    localparam int IDX_W  = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int PER_W  = $clog2(PERIOD + 1);
    localparam int SUM_W  = ((CNT_W > 6) ? CNT_W : 6) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Synchronisers come out of reset holding the good pattern (Q_N high, Q low).
    localparam logic [RW-1:0] SYNC_RST = {{(2*N_BLOCKS){1'b1}}, {(4*N_BLOCKS){1'b0}},
                                          {(4*N_BLOCKS){1'b1}}, {N_BLOCKS{1'b1}},
                                          {(4*N_BLOCKS){1'b1}}, {(27*N_BLOCKS){1'b0}}};

    typedef enum logic [1:0] {IDLE, SETTLE, SCAN, DONE} state_t;

    state_t                        state_q, state_d;
    logic [RW-1:0]                 raw, s1, s2;
    logic [N_BLOCKS-1:0][39:0]     masks;
    logic [39:0]                   cur;
    logic [5:0]                    pop, low;
    logic [SUM_W-1:0]              sum;
    logic [IDX_W-1:0]              blk_idx;
    logic [SET_W-1:0]              settle_cnt;
    logic [PER_W-1:0]              per_cnt;
    logic                          auto_trig, found;
    logic                          done_q, valid_q, pass_q;
    logic [N_BLOCKS-1:0]           fail_map_q;
    logic [CNT_W-1:0]              err_q;
    logic [3:0]                    first_blk_q;
    logic [5:0]                    first_bit_q;

    assign raw = {bus.spare_xfqn, bus.spare_xfq, bus.spare_xmx, bus.spare_xno,
                  bus.spare_xna, bus.spare_xib, bus.spare_xi, bus.spare_xz};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= SYNC_RST;
            s2 <= SYNC_RST;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    for (genvar b = 0; b < N_BLOCKS; b++) begin : g_blk
        spare_block_check u_chk (
            .xz   (s2[27*b +: 27]),
            .xi   (s2[O_XI + 4*b +: 4]),
            .xib  (s2[O_XIB + b]),
            .xna  (s2[O_XNA + 2*b +: 2]),
            .xno  (s2[O_XNO + 2*b +: 2]),
            .xmx  (s2[O_XMX + 2*b +: 2]),
            .xfq  (s2[O_XFQ + 2*b +: 2]),
            .xfqn (s2[O_XFQN + 2*b +: 2]),
            .mask (masks[b])
        );
    end

    assign cur = masks[blk_idx];

    always_comb begin
        pop = '0;
        low = '0;
        for (int k = 0; k < 40; k++) pop = pop + 6'(cur[k]);
        for (int k = 39; k >= 0; k--) if (cur[k]) low = 6'(k);
        sum = SUM_W'(err_q) + SUM_W'(pop);
    end

    assign auto_trig = (state_q == IDLE) && bus.auto_en && (per_cnt == PER_W'(PERIOD - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start || auto_trig) state_d = SETTLE;
            SETTLE:  if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) state_d = SCAN;
            SCAN:    if (blk_idx == IDX_W'(N_BLOCKS - 1)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            per_cnt     <= '0;
            settle_cnt  <= '0;
            blk_idx     <= '0;
            found       <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            pass_q      <= 1'b0;
            fail_map_q  <= '0;
            err_q       <= '0;
            first_blk_q <= '0;
            first_bit_q <= '0;
        end else begin
            per_cnt    <= (state_q == IDLE && bus.auto_en && !auto_trig) ? per_cnt + 1'b1 : '0;
            settle_cnt <= (state_q == SETTLE) ? settle_cnt + 1'b1 : '0;
            blk_idx    <= (state_q == SCAN) ? blk_idx + 1'b1 : '0;
            done_q     <= (state_q == DONE);
            if (state_q == IDLE && state_d == SETTLE) begin
                fail_map_q  <= '0;
                err_q       <= '0;
                first_blk_q <= '0;
                first_bit_q <= '0;
                found       <= 1'b0;
            end
            if (state_q == SCAN) begin
                fail_map_q[blk_idx] <= |cur;
                err_q <= (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum);
                if (!found && |cur) begin
                    found       <= 1'b1;
                    first_blk_q <= 4'(blk_idx);
                    first_bit_q <= low;
                end
            end
            if (state_q == DONE) begin
                valid_q <= 1'b1;
                pass_q  <= (fail_map_q == '0);
            end
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.result_valid = valid_q;
    assign bus.pass         = pass_q;
    assign bus.fail_map     = fail_map_q;
    assign bus.err_count    = err_q;
    assign bus.first_blk    = first_blk_q;
    assign bus.first_bit    = first_bit_q;
endmodule

// File: tb/tb_spare_logic_monitor.sv
// Directed bench for spare_logic_monitor: two instances (8-bit and 4-bit error
// counters) share the same spare taps; expected values are hand-derived.
module tb_spare_logic_monitor;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic auto_en = 1'b0;
    logic [27*N-1:0] xz;
    logic [4*N-1:0]  xi;
    logic [N-1:0]    xib;
    logic [2*N-1:0]  xna, xno, xmx, xfq, xfqn;
    int checks = 0;
    int errors = 0;
    int lat, bcnt, n, dcnt;

    spare_logic_monitor_if #(.N_BLOCKS(N), .CNT_W(8)) if_a ();
    spare_logic_monitor_if #(.N_BLOCKS(N), .CNT_W(4)) if_b ();

    assign if_a.start = start;      assign if_b.start = start;
    assign if_a.auto_en = auto_en;  assign if_b.auto_en = auto_en;
    assign if_a.spare_xz = xz;      assign if_b.spare_xz = xz;
    assign if_a.spare_xi = xi;      assign if_b.spare_xi = xi;
    assign if_a.spare_xib = xib;    assign if_b.spare_xib = xib;
    assign if_a.spare_xna = xna;    assign if_b.spare_xna = xna;
    assign if_a.spare_xno = xno;    assign if_b.spare_xno = xno;
    assign if_a.spare_xmx = xmx;    assign if_b.spare_xmx = xmx;
    assign if_a.spare_xfq = xfq;    assign if_b.spare_xfq = xfq;
    assign if_a.spare_xfqn = xfqn;  assign if_b.spare_xfqn = xfqn;

    spare_logic_monitor #(.N_BLOCKS(N), .SETTLE_CYCLES(4), .PERIOD(16), .CNT_W(8)) dut_a (
        .clock(clock), .reset(reset), .bus(if_a));
    spare_logic_monitor #(.N_BLOCKS(N), .SETTLE_CYCLES(4), .PERIOD(16), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .bus(if_b));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_good();
        xz = '0; xi = '1; xib = '1; xna = '1; xno = '1; xmx = '0;
        xfq = 8'h5A; xfqn = 8'hA5;
    endtask

    // Pulse start, count edges until done and how many samples showed busy.
    task automatic run_scan(output int l, output int b);
        start = 1'b1;
        tick();
        start = 1'b0;
        b = if_a.busy ? 1 : 0;
        l = 0;
        while (!if_a.done && l < 40) begin
            tick();
            l++;
            if (if_a.busy) b++;
        end
    endtask

    initial begin
        set_good();
        #1;
        chk("rst_busy", 32'(if_a.busy), 0);
        chk("rst_done", 32'(if_a.done), 0);
        chk("rst_valid", 32'(if_a.result_valid), 0);
        chk("rst_pass", 32'(if_a.pass), 0);
        chk("rst_map", 32'(if_a.fail_map), 0);
        chk("rst_err", 32'(if_a.err_count), 0);
        chk("rst_fblk", 32'(if_a.first_blk), 0);
        chk("rst_fbit", 32'(if_a.first_bit), 0);
        #11 reset = 1'b0;
        repeat (3) tick();

        // Clean run
        run_scan(lat, bcnt);
        chk("good_lat", 32'(lat), 9);
        chk("good_busy", 32'(bcnt), 9);
        chk("good_pass", 32'(if_a.pass), 1);
        chk("good_map", 32'(if_a.fail_map), 0);
        chk("good_err", 32'(if_a.err_count), 0);
        chk("good_valid", 32'(if_a.result_valid), 1);
        tick();
        chk("done_pulse", 32'(if_a.done), 0);

        // Block 2 inverter 3 stuck low
        xi[11] = 1'b0;
        repeat (3) tick();
        run_scan(lat, bcnt);
        chk("xi_map", 32'(if_a.fail_map), 32'h4);
        chk("xi_err", 32'(if_a.err_count), 1);
        chk("xi_fblk", 32'(if_a.first_blk), 2);
        chk("xi_fbit", 32'(if_a.first_bit), 30);
        chk("xi_pass", 32'(if_a.pass), 0);

        // Block 0 flop pair not complementary, block 3 tie-off 5 high
        set_good();
        xfq[1] = 1'b1; xfqn[1] = 1'b1; xz[86] = 1'b1;
        repeat (3) tick();
        run_scan(lat, bcnt);
        chk("mix_map", 32'(if_a.fail_map), 32'h9);
        chk("mix_err", 32'(if_a.err_count), 2);
        chk("mix_fblk", 32'(if_a.first_blk), 0);
        chk("mix_fbit", 32'(if_a.first_bit), 39);

        // Block 1 all tie-offs high: 27 errors, 4-bit counter saturates
        set_good();
        xz[53:27] = '1;
        repeat (3) tick();
        run_scan(lat, bcnt);
        chk("sat_err_b", 32'(if_b.err_count), 15);
        chk("sat_fblk_b", 32'(if_b.first_blk), 1);
        chk("sat_fbit_b", 32'(if_b.first_bit), 0);
        chk("sat_err_a", 32'(if_a.err_count), 27);

        // start re-pulsed mid-scan is dropped
        set_good();
        xi[11] = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        dcnt = 0;
        for (int c = 1; c <= 25; c++) begin
            start = (c == 5);
            tick();
            if (if_a.done) dcnt++;
        end
        start = 1'b0;
        chk("repulse_dones", 32'(dcnt), 1);
        chk("repulse_map", 32'(if_a.fail_map), 32'h4);
        chk("repulse_err", 32'(if_a.err_count), 1);
        set_good();
        repeat (3) tick();
        run_scan(lat, bcnt);
        chk("repulse_good", 32'(if_a.pass), 1);

        // Auto mode, PERIOD=16
        repeat (2) tick();
        auto_en = 1'b1;
        n = 0;
        while (!if_a.busy && n < 100) begin tick(); n++; end
        chk("auto_first", 32'(n), 16);
        n = 0;
        while (!if_a.done && n < 100) begin tick(); n++; end
        chk("auto_lat", 32'(n), 9);
        n = 0;
        while (!if_a.busy && n < 100) begin tick(); n++; end
        chk("auto_period", 32'(n), 16);
        auto_en = 1'b0;
        n = 0;
        while (!if_a.done && n < 100) begin tick(); n++; end
        tick();

        // Reset mid-scan aborts the run
        xi[11] = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("abort_pre_map", 32'(if_a.fail_map), 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(if_a.busy), 0);
        chk("abort_map", 32'(if_a.fail_map), 0);
        chk("abort_err", 32'(if_a.err_count), 0);
        chk("abort_valid", 32'(if_a.result_valid), 0);
        chk("abort_fblk", 32'(if_a.first_blk), 0);
        set_good();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        run_scan(lat, bcnt);
        chk("post_lat", 32'(lat), 9);
        chk("post_pass", 32'(if_a.pass), 1);
        chk("post_valid", 32'(if_a.result_valid), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
